// File: rtl/q_row_fetch.sv
// Reads one board state's nine per-cell Q-values from a 1-cycle RAM and presents them, registered, to the max-Q comparator.
// Optional ILLEGAL_MASK_EN: occupied cells (latched board bits != 00) are captured as 0.
module q_row_fetch #(
    parameter int unsigned Q_W     = 16,
    parameter int unsigned STATE_W = 15,
    localparam int unsigned ADDR_W = STATE_W + 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_idx,
    input  logic [17:0]        board,
    output logic               busy,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [Q_W-1:0]     ram_rdata,
    output logic [Q_W-1:0]     q_1,
    output logic [Q_W-1:0]     q_2,
    output logic [Q_W-1:0]     q_3,
    output logic [Q_W-1:0]     q_4,
    output logic [Q_W-1:0]     q_5,
    output logic [Q_W-1:0]     q_6,
    output logic [Q_W-1:0]     q_7,
    output logic [Q_W-1:0]     q_8,
    output logic [Q_W-1:0]     q_9,
    output logic               valid
);

    localparam int unsigned N_CELL    = 9;
    localparam int unsigned CELL_W    = 4;
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(N_CELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state, state_d;
    logic [CELL_W-1:0]    cnt, cnt_d, cnt_nx;
    logic [STATE_W-1:0]   state_l, state_l_d;
    logic [17:0]          board_l, board_l_d;
    logic                 busy_d;
    logic                 rd_en_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 valid_d;

    // Control registers, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            state_l   <= '0;
            board_l   <= '0;
            busy      <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
            valid     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            state_l   <= state_l_d;
            board_l   <= board_l_d;
            busy      <= busy_d;
            ram_rd_en <= rd_en_d;
            ram_addr  <= addr_d;
            valid     <= valid_d;
        end
    end

    // Next-state and next-output logic; cnt tracks the cell currently on ram_addr
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        state_l_d = state_l;
        board_l_d = board_l;
        busy_d    = busy;
        rd_en_d   = 1'b0;
        addr_d    = ram_addr;
        valid_d   = 1'b0;
        cnt_nx    = cnt + CELL_W'(1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    cnt_d     = '0;
                    state_l_d = state_idx;
                    board_l_d = board;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    addr_d    = {state_idx, CELL_W'(0)};
                end
            end
            S_READ: begin
                if (cnt == LAST_CELL) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_nx;
                    rd_en_d = 1'b1;
                    addr_d  = {state_l, cnt_nx};
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    logic              cap_vld;
    logic [CELL_W-1:0] cap_cell;
    logic [Q_W-1:0]    cap_q;
    logic [Q_W-1:0]    q_r [N_CELL];

`ifdef ILLEGAL_MASK_EN
    logic occupied;

    // Occupied cells are forced to the minimum Q so the max never picks them
    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < int'(N_CELL); i++) begin
            if (cap_cell == CELL_W'(i)) begin
                occupied = |board_l[2*i +: 2];
            end
        end
        cap_q = occupied ? '0 : ram_rdata;
    end
`else
    logic unused_board;

    assign unused_board = ^board_l;
    assign cap_q        = ram_rdata;
`endif

    // Read-data pipeline: flag and cell tag follow the address by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld  <= 1'b0;
            cap_cell <= '0;
            for (int i = 0; i < int'(N_CELL); i++) begin
                q_r[i] <= '0;
            end
        end else begin
            cap_vld  <= ram_rd_en;
            cap_cell <= ram_addr[CELL_W-1:0];
            for (int i = 0; i < int'(N_CELL); i++) begin
                if (cap_vld && (cap_cell == CELL_W'(i))) begin
                    q_r[i] <= cap_q;
                end
            end
        end
    end

    assign q_1 = q_r[0];
    assign q_2 = q_r[1];
    assign q_3 = q_r[2];
    assign q_4 = q_r[3];
    assign q_5 = q_r[4];
    assign q_6 = q_r[5];
    assign q_7 = q_r[6];
    assign q_8 = q_r[7];
    assign q_9 = q_r[8];

endmodule

// File: tb/tb_q_row_fetch.sv
// Bench for q_row_fetch: 1-cycle RAM model returning s*16+c+100, scoreboard queues of expected addresses and Q-values.
module tb_q_row_fetch;

    localparam int unsigned Q_W     = 16;
    localparam int unsigned STATE_W = 15;
    localparam int unsigned ADDR_W  = STATE_W + 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [STATE_W-1:0] state_idx;
    logic [17:0]        board;
    logic               busy;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_addr;
    logic [Q_W-1:0]     ram_rdata = '0;
    logic [Q_W-1:0]     q_1, q_2, q_3, q_4, q_5, q_6, q_7, q_8, q_9;
    logic               valid;
    logic [Q_W-1:0]     q_obs [9];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [ADDR_W-1:0] addr_q [$];
    logic [Q_W-1:0]    q_q [$];

    q_row_fetch #(.Q_W(Q_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .state_idx(state_idx), .board(board),
        .busy(busy), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .q_1(q_1), .q_2(q_2), .q_3(q_3), .q_4(q_4), .q_5(q_5), .q_6(q_6),
        .q_7(q_7), .q_8(q_8), .q_9(q_9), .valid(valid)
    );

    always #5 clk = ~clk;

    // Synchronous Q-table RAM: {s,c} -> s*16+c+100
    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= Q_W'(int'(ram_addr) + 100);
    end

    assign q_obs[0] = q_1;
    assign q_obs[1] = q_2;
    assign q_obs[2] = q_3;
    assign q_obs[3] = q_4;
    assign q_obs[4] = q_5;
    assign q_obs[5] = q_6;
    assign q_obs[6] = q_7;
    assign q_obs[7] = q_8;
    assign q_obs[8] = q_9;

    function automatic logic [Q_W-1:0] exp_q(input int s, input int c, input logic [17:0] brd);
        logic mask_on;
        logic [Q_W-1:0] v;
`ifdef ILLEGAL_MASK_EN
        mask_on = 1'b1;
`else
        mask_on = 1'b0;
`endif
        v = Q_W'(s * 16 + c + 100);
        if (mask_on && (brd[2*c +: 2] != 2'b00)) v = '0;
        return v;
    endfunction

    task automatic push_fetch(input int s, input logic [17:0] brd);
        for (int c = 0; c < 9; c++) begin
            addr_q.push_back(ADDR_W'(s * 16 + c));
            q_q.push_back(exp_q(s, c, brd));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        state_idx = 15'd9;
        board = '0;
        repeat (3) cycle();
        n_checks++;
        if ({busy, ram_rd_en, valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/rd_en/valid=%b expected 000", {busy, ram_rd_en, valid});
        end
        n_checks++;
        if (ram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0h expected 0", ram_addr);
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (q_obs[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_q%0d: got %0d expected 0", k + 1, q_obs[k]);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (3) begin
            cycle();
            n_checks++;
            if ({busy, ram_rd_en, valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle: busy/rd_en/valid=%b expected 000", {busy, ram_rd_en, valid});
            end
        end
    endtask

    // One fetch from cycle 0; optional state_idx change at chg_cyc
    task automatic test_fetch(input string name, input int s, input logic [17:0] brd,
                              input int chg_cyc, input int new_s);
        logic [ADDR_W-1:0] ea;
        logic [Q_W-1:0]    eq;
        push_fetch(s, brd);
        state_idx = STATE_W'(s);
        board = brd;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (busy !== (c <= 11) || valid !== (c == 11) || ram_rd_en !== (c <= 9)) begin
                n_fail++;
                $display("FAIL %s_ctrl cyc%0d: busy=%b valid=%b rd_en=%b expected %b %b %b",
                         name, c, busy, valid, ram_rd_en, c <= 11, c == 11, c <= 9);
            end
            if (ram_rd_en === 1'b1 && addr_q.size() > 0) begin
                ea = addr_q.pop_front();
                n_checks++;
                if (ram_addr !== ea) begin
                    n_fail++;
                    $display("FAIL %s_addr cyc%0d: got %0d expected %0d", name, c, ram_addr, ea);
                end
            end
            if (valid === 1'b1) begin
                for (int k = 0; k < 9; k++) begin
                    eq = (q_q.size() > 0) ? q_q.pop_front() : 'x;
                    n_checks++;
                    if (q_obs[k] !== eq) begin
                        n_fail++;
                        $display("FAIL %s_q%0d: got %0d expected %0d", name, k + 1, q_obs[k], eq);
                    end
                end
            end
            if (c == chg_cyc) state_idx = STATE_W'(new_s);
        end
        n_checks++;
        if (addr_q.size() != 0 || q_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d addrs, %0d qs left expected 0 0", name, addr_q.size(), q_q.size());
        end
        addr_q.delete();
        q_q.delete();
    endtask

    task automatic test_start_held();
        logic exp_rd, exp_valid, exp_busy;
        logic [ADDR_W-1:0] ea;
        logic [Q_W-1:0]    eq;
        push_fetch(2, '0);
        push_fetch(2, '0);
        state_idx = 15'd2;
        board = '0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cycle();
            if (c == 20) start = 1'b0;
            exp_rd    = (c >= 1 && c <= 9) || (c >= 13 && c <= 21);
            exp_valid = (c == 11) || (c == 23);
            exp_busy  = (c >= 1 && c <= 11) || (c >= 13 && c <= 23);
            n_checks++;
            if (busy !== exp_busy || valid !== exp_valid || ram_rd_en !== exp_rd) begin
                n_fail++;
                $display("FAIL held_ctrl cyc%0d: busy=%b valid=%b rd_en=%b expected %b %b %b",
                         c, busy, valid, ram_rd_en, exp_busy, exp_valid, exp_rd);
            end
            if (ram_rd_en === 1'b1 && addr_q.size() > 0) begin
                ea = addr_q.pop_front();
                n_checks++;
                if (ram_addr !== ea) begin
                    n_fail++;
                    $display("FAIL held_addr cyc%0d: got %0d expected %0d", c, ram_addr, ea);
                end
            end
            if (valid === 1'b1) begin
                for (int k = 0; k < 9; k++) begin
                    eq = (q_q.size() > 0) ? q_q.pop_front() : 'x;
                    n_checks++;
                    if (q_obs[k] !== eq) begin
                        n_fail++;
                        $display("FAIL held_q%0d cyc%0d: got %0d expected %0d", k + 1, c, q_obs[k], eq);
                    end
                end
            end
        end
        n_checks++;
        if (addr_q.size() != 0 || q_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_drain: %0d addrs, %0d qs left expected 0 0", addr_q.size(), q_q.size());
        end
        addr_q.delete();
        q_q.delete();
    endtask

    task automatic test_reset_abort();
        state_idx = 15'd3;
        board = '0;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cycle();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (ram_rd_en !== 1'b1 || ram_addr !== ADDR_W'(3 * 16 + c - 1)) begin
                n_fail++;
                $display("FAIL abort_read cyc%0d: rd_en=%b addr=%0d expected 1 %0d",
                         c, ram_rd_en, ram_addr, 3 * 16 + c - 1);
            end
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({busy, ram_rd_en, valid} !== 3'b000 || ram_addr !== '0) begin
            n_fail++;
            $display("FAIL abort_ctrl: busy/rd_en/valid=%b addr=%0d expected 000 0",
                     {busy, ram_rd_en, valid}, ram_addr);
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (q_obs[k] !== '0) begin
                n_fail++;
                $display("FAIL abort_q%0d: got %0d expected 0", k + 1, q_obs[k]);
            end
        end
        for (int c = 7; c <= 14; c++) begin
            cycle();
            n_checks++;
            if ({busy, ram_rd_en, valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_idle cyc%0d: busy/rd_en/valid=%b expected 000", c, {busy, ram_rd_en, valid});
            end
        end
        test_fetch("after_abort", 6, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        state_idx = '0;
        board = '0;
        test_reset();
        test_fetch("basic", 5, '0, 0, 0);
        test_start_held();
        cycle();
        test_fetch("mask", 5, 18'b00_00_00_00_00_00_00_10_01, 0, 0);
        test_fetch("idx_change", 5, '0, 3, 7);
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
